cache_axi_bridge: RTL
=====================

# cache_axi_bridge

Converts the scalar cache controller's line-refill and line-writeback requests into AXI4 full bursts on the scalar master port (`s_m_axi_*`) of the memory subsystem. It sits directly downstream of `cache_contr_nway_vnv`, driving its `axi_read_*` and `axi_write_*` handshake pins. One refill or one writeback moves exactly one cache block as a single INCR burst. The read and write channels run as independent state machines.

## Interface

Parameters:
- `C_M_AXI_ADDR_WIDTH`, 32: AXI address width.
- `C_M_AXI_DATA_WIDTH`, 32: AXI data width; must be 32 or 64.
- `C_BLOCK_SIZE`, 64: cache block size in bytes.
  - BEATS = C_BLOCK_SIZE*8/C_M_AXI_DATA_WIDTH; must be 2..256.
  - OFF = log2(C_BLOCK_SIZE).

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `rd_addr_i` in ADDR: refill address; sampled with `rd_init_i`.
- `rd_init_i` in 1: one-cycle refill request pulse.
- `rd_data_o` out DATA: refill beat data.
- `rd_next_o` out 1: `rd_data_o` valid this cycle.
- `rd_done_o` out 1: last refill beat; coincides with the final `rd_next_o`.
- `rd_busy_o` out 1: read FSM not idle.
- `wr_addr_i` in ADDR: writeback address; sampled with `wr_init_i`.
- `wr_init_i` in 1: one-cycle writeback request pulse.
- `wr_data_i` in DATA: current writeback word, supplied by the cache.
- `wr_next_o` out 1: current word consumed; the cache presents the next word on the following cycle.
- `wr_done_o` out 1: write response received.
- `wr_busy_o` out 1: write FSM not idle.
- `s_m_axi_ar*` / `r*` / `aw*` / `w*` / `b*`: AXI ports with the same names, directions and widths as the memory subsystem's scalar port.

## Operation

Address handling:
- Both burst addresses are block-aligned: `addr & ~(C_BLOCK_SIZE-1)`.
- `arlen` = `awlen` = BEATS-1.
- `wstrb` is all ones.

Read FSM, states R_IDLE, R_ADDR, R_DATA:
- R_IDLE: on `rd_init_i`, register the aligned address and go to R_ADDR.
- R_ADDR: `arvalid`=1. On `arready`, go to R_DATA.
- R_DATA: `rready`=1.
  - Each `rvalid` registers `rdata` into `rd_data_o` and pulses `rd_next_o` for one cycle.
  - On `rlast`, also pulse `rd_done_o` and return to R_IDLE.
  - Beat count is not checked against `rlast`; `rlast` terminates the burst.

Write FSM, states W_IDLE, W_BURST, W_RESP:
- W_IDLE: on `wr_init_i`, register the aligned address, clear the beat counter, go to W_BURST.
- W_BURST:
  - `awvalid`=1 until `awready`; it is held independently of W-channel progress.
  - `wvalid`=1 with `wdata`=`wr_data_i`.
  - `wr_next_o` = `wvalid & wready`, combinational.
  - `wlast`=1 when the beat counter equals BEATS-1.
  - Leave for W_RESP only when both the AW handshake and the last W handshake have completed, in either order.
- W_RESP: `bready`=1. On `bvalid`, pulse `wr_done_o` and return to W_IDLE.

Request and channel rules:
- An `*_init_i` pulse while the corresponding FSM is busy is ignored. The cache must check `*_busy_o` before pulsing.
- The read and write FSMs may be active simultaneously.
- `rresp`/`bresp` are not observed.

## Timing

Reset:
- All FSMs return to idle; the beat counter clears.
- Reset value of all outputs is 0: every valid, ready, last, next, done and busy signal, `rd_data_o`, and all addresses.
- `awlen`/`arlen` reset to 0; `wdata` follows `wr_data_i` combinationally.
- A reset asserted mid-burst abandons the burst with no done pulse.

Latencies:
- `arvalid` and `awvalid` rise on the cycle after the `init` pulse.
- `wvalid` rises on the cycle after the `init` pulse.
- Read data path: `rd_next_o` follows the R handshake by 1 cycle.
- `wr_done_o` follows the B handshake by 1 cycle.
- `*_busy_o` rises on the cycle after the init pulse and falls on the same cycle as the corresponding done pulse.
- Minimum turnaround: a new init is accepted on the cycle `*_busy_o` is low.

Handshake rules:
- `arvalid`, `awvalid` and `wvalid` never drop before their handshake completes.
- Address and data are stable while valid is high.

## Configuration

`CACHE_AXI_BRIDGE_WR_ORDER_EN`:
- Defined: a read init accepted while `wr_busy_o`=1 waits in R_ADDR with `arvalid`=0 until the cycle after `wr_done_o`. This guarantees a writeback reaches memory before any refill is issued.
- Undefined: `arvalid` rises independently of write state.

## Test plan

- Refill: `rd_init_i` with `rd_addr_i`=0x1000_0024, `rready` path always valid.
  - Expect `araddr`=0x1000_0000 and `arlen`=15 (32-bit data, 64-byte block).
  - Expect 16 `rd_next_o` pulses carrying rdata 0..15.
  - Expect `rd_done_o` with the 16th pulse.
- Writeback: `wr_addr_i`=0x2000_0040, `wready` toggled 1/0 every cycle, `awready` delayed 5 cycles after `awvalid`.
  - Expect 16 `wr_next_o` pulses.
  - Expect `wlast` only on beat 15.
  - Expect a single `wr_done_o` 1 cycle after `bvalid`, with `bvalid` issued 3 cycles after `wlast`.
- Init pulse while busy: `rd_init_i` during R_DATA.
  - Expect no second AR and `rd_busy_o` staying 1 until `rd_done_o`.
- Concurrent traffic: read and write inits on the same cycle.
  - Without the macro: `arvalid` and `awvalid` both high on the next cycle.
  - With `CACHE_AXI_BRIDGE_WR_ORDER_EN`: `arvalid` low until the cycle after `wr_done_o`.
- Reset mid-burst: `rstn`=0 after beat 7 of a refill.
  - Expect all outputs 0 immediately (asynchronous) and no `rd_done_o`.
  - After release, a new refill completes normally.

Source files
------------

// File: rtl/cache_axi_bridge_if.sv
// cache_axi_bridge_if: AXI4 master bundle between the cache bridge and the memory subsystem scalar port.
interface cache_axi_bridge_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
);
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata, wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic arvalid, arready, rvalid, rready, rlast;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: cache line refill/writeback to single AXI4 INCR bursts, independent read and write FSMs.
// CACHE_AXI_BRIDGE_WR_ORDER_EN holds a refill's AR until any in-flight writeback has completed.
module cache_axi_bridge #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_BLOCK_SIZE       = 64
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                          rd_init_i,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data_o,
  output logic                          rd_next_o,
  output logic                          rd_done_o,
  output logic                          rd_busy_o,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic                          wr_init_i,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] wr_data_i,
  output logic                          wr_next_o,
  output logic                          wr_done_o,
  output logic                          wr_busy_o,
  cache_axi_bridge_if.master            axi
);
  localparam int BEATS = C_BLOCK_SIZE * 8 / C_M_AXI_DATA_WIDTH;
  localparam logic [7:0] LEN = 8'(BEATS - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] MASK = ~C_M_AXI_ADDR_WIDTH'(C_BLOCK_SIZE - 1);
  localparam logic [2:0] SIZE = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} w_state_t;
  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic [7:0] cnt;
  logic aw_done, w_done, r_hold;
  assign axi.arsize  = SIZE;
  assign axi.awsize  = SIZE;
  assign axi.arburst = 2'b01;
  assign axi.awburst = 2'b01;
  assign axi.wstrb   = '1;
  assign axi.wdata   = wr_data_i;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_init_i) r_next = R_ADDR;
      R_ADDR:  if (axi.arvalid && axi.arready) r_next = R_DATA;
      R_DATA:  if (axi.rvalid && axi.rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_init_i) w_next = W_BURST;
      W_BURST: if ((aw_done || (axi.awvalid && axi.awready)) && (w_done || (wr_next_o && axi.wlast))) w_next = W_RESP;
      W_RESP:  if (axi.bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end
  always_comb begin
    rd_busy_o   = r_state != R_IDLE;
    axi.arvalid = r_state == R_ADDR && !r_hold;
    axi.rready  = r_state == R_DATA;
    wr_busy_o   = w_state != W_IDLE;
    axi.awvalid = w_state == W_BURST && !aw_done;
    axi.wvalid  = w_state == W_BURST && !w_done;
    axi.wlast   = axi.wvalid && cnt == LEN;
    axi.bready  = w_state == W_RESP;
    wr_next_o   = axi.wvalid && axi.wready;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      axi.araddr <= '0;
      axi.awaddr <= '0;
      axi.arlen  <= '0;
      axi.awlen  <= '0;
      rd_data_o  <= '0;
      rd_next_o  <= 1'b0;
      rd_done_o  <= 1'b0;
      wr_done_o  <= 1'b0;
      cnt        <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      axi.arlen <= LEN;
      axi.awlen <= LEN;
      if (r_state == R_IDLE && rd_init_i) axi.araddr <= rd_addr_i & MASK;
      if (axi.rready && axi.rvalid) rd_data_o <= axi.rdata;
      rd_next_o <= axi.rready && axi.rvalid;
      rd_done_o <= axi.rready && axi.rvalid && axi.rlast;
      wr_done_o <= axi.bready && axi.bvalid;
      if (w_state == W_IDLE && wr_init_i) begin
        axi.awaddr <= wr_addr_i & MASK;
        cnt        <= '0;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end else begin
        if (axi.awvalid && axi.awready) aw_done <= 1'b1;
        if (wr_next_o) begin
          cnt <= cnt + 8'd1;
          if (axi.wlast) w_done <= 1'b1;
        end
      end
    end
`ifdef CACHE_AXI_BRIDGE_WR_ORDER_EN
  // A refill accepted while a writeback is pending or starting waits for its B response.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_hold <= 1'b0;
    else if (r_state == R_IDLE && rd_init_i) r_hold <= wr_busy_o || wr_init_i;
    else if (wr_done_o) r_hold <= 1'b0;
`else
  assign r_hold = 1'b0;
`endif
endmodule
